gf_mix_column_seq: RTL and testbench

//  Sequential AES (Inv)MixColumns engine; replaces per-coefficient GF(2^8) lookup ROMs.

---
 rtl/gf_mix_column_seq.sv | 126 ++++++++++++
 tb/tb_gf_mix_column_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mix_column_seq.sv
// Sequential AES (Inv)MixColumns engine: one 32-bit column per clock, xtime-based GF(2^8) products.
// Define GF_MIX_INV_EN to build the inverse datapath and honour the inv port.
module gf_mix_column_seq #(
  parameter int NUM_COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     inv,
  input  logic [32*NUM_COLS-1:0]   data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*NUM_COLS-1:0]   data_out,
  output logic                     busy
);
  localparam int W  = 32 * NUM_COLS;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);

  if (NUM_COLS < 1 || NUM_COLS > 8) begin : g_bad_cols
    $error("gf_mix_column_seq: NUM_COLS must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nxt;
  logic [31:0]   col_res;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = xt(a[i]) ^ xt(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    return r;
  endfunction

`ifdef GF_MIX_INV_EN
  logic mode;

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [7:0]  m9 [4], m11 [4], m13 [4], m14 [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = m14[i] ^ m11[(i+1)%4] ^ m13[(i+2)%4] ^ m9[(i+3)%4];
    return r;
  endfunction

  assign col_res = mode ? mix_inv(work[W-1 -: 32]) : mix_fwd(work[W-1 -: 32]);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign col_res    = mix_fwd(work[W-1 -: 32]);
`endif

  // The work register rotates one column per cycle: the head column is mixed and
  // re-enters at the tail, so after NUM_COLS steps the packing is back in order.
  if (NUM_COLS == 1) begin : g_one
    assign work_nxt = col_res;
  end else begin : g_many
    assign work_nxt = {work[W-33:0], col_res};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = CALC;
      CALC:    if (col == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      col      <= '0;
      work     <= '0;
      data_out <= '0;
`ifdef GF_MIX_INV_EN
      mode     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          work <= data_in;
          col  <= '0;
`ifdef GF_MIX_INV_EN
          mode <= inv;
`endif
        end
        CALC: begin
          work <= work_nxt;
          if (col == LAST) data_out <= work_nxt;
          else             col      <= col + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gf_mix_column_seq.sv
// Bench for gf_mix_column_seq: NUM_COLS=4 and NUM_COLS=1 instances, table vectors, random vs GF model.
module tb_gf_mix_column_seq;
`ifdef GF_MIX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  localparam logic [7:0] FC [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] IC [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, inv, out_valid, out_ready, busy;
  logic [127:0] data_in, data_out;
  logic         in_valid1, in_ready1, inv1, out_valid1, out_ready1, busy1;
  logic [31:0]  data_in1, data_out1;

  int errors = 0;
  int checks = 0;

  gf_mix_column_seq #(.NUM_COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy));

  gf_mix_column_seq #(.NUM_COLS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .inv(inv1),
    .data_in(data_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .data_out(data_out1), .busy(busy1));

  typedef struct {
    logic [127:0] din;
    logic         iv;
    logic [127:0] exp;
  } vec_t;

  vec_t tab4 [4];
  vec_t tab1 [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply, poly 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] d, input bit iv, input int nc);
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    for (int c = 0; c < nc; c++) begin
      for (int k = 0; k < 4; k++) a[k] = d[(nc-1-c)*32 + (3-k)*8 +: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(iv ? IC[(j-i+4)%4] : FC[(j-i+4)%4], a[j]);
        r[(nc-1-c)*32 + (3-i)*8 +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic xact4(input logic [127:0] d, input logic iv, input logic [127:0] exp, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, ".rdy"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1; data_in = d; inv = iv;
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = {4{$urandom}}; inv = ~iv;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, ".lat"}, 128'(cyc), 128'(4));
    chk({nm, ".data"}, data_out, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".idle"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  task automatic xact1(input logic [31:0] d, input logic [31:0] exp, input string nm);
    int cyc;
    @(negedge clk);
    in_valid1 = 1'b1; data_in1 = d; inv1 = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0; data_in1 = $urandom; inv1 = 1'b1;
    cyc = 0;
    while (!out_valid1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, ".lat"}, 128'(cyc), 128'(1));
    chk({nm, ".data"}, 128'(data_out1), 128'(exp));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk({nm, ".idle"}, 128'({out_valid1, in_ready1}), 128'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, exp;
    logic         iv;
    int           cyc;
    int           acc_q [$];

    tab4[0] = '{128'hdb135345_f20a225c_01010101_2d26314c, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8};
    tab4[1] = '{128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1,
                INV_EN ? 128'hdb135345_f20a225c_01010101_2d26314c
                       : ref_mix(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0, 4)};
    tab4[2] = '{128'h0, 1'b0, 128'h0};
    tab4[3] = '{{4{32'h01010101}}, 1'b1, {4{32'h01010101}}};
    tab1[0] = '{128'(32'hc6c6c6c6), 1'b0, 128'(32'hc6c6c6c6)};
    tab1[1] = '{128'(32'hd4d4d4d5), 1'b0, 128'(32'hd5d5d7d6)};
    tab1[2] = '{128'(32'hf20a225c), 1'b0, 128'(32'h9fdc589d)};

    rst_n = 1'b0;
    in_valid = 0; inv = 0; out_ready = 0; data_in = '0;
    in_valid1 = 0; inv1 = 0; out_ready1 = 0; data_in1 = '0;
    #12;
    chk("reset.ctl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset.data", data_out, 128'h0);
    chk("reset1.ctl", 128'({in_ready1, out_valid1, busy1}), 128'(3'b100));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle.data", data_out, 128'h0);

    foreach (tab4[i]) xact4(tab4[i].din, tab4[i].iv, tab4[i].exp, $sformatf("tab4[%0d]", i));
    foreach (tab1[i]) xact1(tab1[i].din[31:0], tab1[i].exp[31:0], $sformatf("tab1[%0d]", i));

    for (int i = 0; i < 8; i++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      iv = 1'($urandom_range(0, 1));
      xact4(d, iv, ref_mix(d, iv & INV_EN, 4), $sformatf("rnd4[%0d]", i));
    end
    for (int i = 0; i < 4; i++) begin
      d = 128'($urandom);
      xact1(d[31:0], 32'(ref_mix(d, 1'b0, 1)), $sformatf("rnd1[%0d]", i));
    end

    // Backpressure: result and handshake state must hold, new requests ignored
    exp = tab4[0].exp;
    @(negedge clk);
    in_valid = 1'b1; data_in = tab4[0].din; inv = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = {4{$urandom}}; inv = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp[%0d].ctl", i), 128'({out_valid, in_ready, busy}), 128'(3'b101));
      chk($sformatf("bp[%0d].data", i), data_out, exp);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.release", 128'({out_valid, in_ready}), 128'(2'b01));
    chk("bp.hold", data_out, exp);
    xact4(tab4[3].din, 1'b0, tab4[3].exp, "bp.next");

    // NUM_COLS=1 back-to-back: accepts every 3 cycles
    @(negedge clk);
    in_valid1 = 1'b1; data_in1 = 32'hd4d4d4d5; inv1 = 1'b0; out_ready1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready1) acc_q.push_back(i);
      if (out_valid1) chk($sformatf("b2b[%0d].data", i), 128'(data_out1), 128'(32'hd5d5d7d6));
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    out_ready1 = 1'b0;
    chk("b2b.count", 128'(acc_q.size()), 128'(4));
    for (int i = 1; i < acc_q.size(); i++)
      chk($sformatf("b2b.gap[%0d]", i), 128'(acc_q[i] - acc_q[i-1]), 128'(3));

    // Reset two cycles into CALC discards the transaction
    @(negedge clk);
    in_valid = 1'b1; data_in = tab4[0].din; inv = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.ctl", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    chk("midrst.data", data_out, 128'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst[%0d].quiet", i), 128'({out_valid, in_ready, data_out}),
          128'({1'b0, 1'b1, 128'h0}));
    end
    xact4(tab4[0].din, 1'b0, tab4[0].exp, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
